alu_op_issuer: RTL and testbench

- Initiator side of the 8-bit ALU operand/opcode interface.
- Accepts operation requests over a valid/ready handshake and drives the combinational ALU's A, B and Op inputs, holding them stable for a programmable settle window.
- Captures the ALU result, optionally writes it to an accumulator, and returns it over a valid/ready response channel.
- Sits between the control/sequencing logic and the ALU datapath.

---
 rtl/alu_op_issuer.sv | 118 +++++++++++
 tb/tb_alu_op_issuer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_issuer.sv
// Initiator for the combinational ALU: accepts op requests, holds A/B/Op for a settle window,
// captures the result (optionally into the accumulator). Optional rsp_flags port via `ALU_FLAGS_EN`.
module alu_op_issuer #(
    parameter int WIDTH = 8,
    parameter int SETTLE_CYCLES = 1,
    parameter logic [WIDTH-1:0] ACC_RESET = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_use_acc,
    input  logic             req_wr_acc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [2:0]       rsp_op,
    output logic [WIDTH-1:0] acc,
    output logic             busy
`ifdef ALU_FLAGS_EN
    ,
    output logic [1:0]       rsp_flags
`endif
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        RESP
    } stateT;

    stateT         state;
    stateT         stateNext;
    logic [CW-1:0] settleCnt;
    logic          wrAccLatched;
    logic          accept;
    logic          capture;
    logic          rspDone;

    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        capture   = 1'b0;
        rspDone   = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                accept = req_valid && req_ready;
                if (accept) stateNext = DRIVE;
            end
            DRIVE: begin
                capture = (settleCnt == '0);
                if (capture) stateNext = RESP;
            end
            RESP: begin
                rspDone = rsp_valid && rsp_ready;
                if (rspDone) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    // req_ready is registered, so it trails reset release and handshake by one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready    <= 1'b0;
            rsp_valid    <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= '0;
            rsp_data     <= '0;
            rsp_op       <= '0;
            acc          <= ACC_RESET;
            settleCnt    <= '0;
            wrAccLatched <= 1'b0;
        end else begin
            req_ready <= (stateNext == IDLE);
            if (accept) begin
                alu_op       <= req_op;
                alu_b        <= req_b;
                alu_a        <= req_use_acc ? acc : req_a;
                wrAccLatched <= req_wr_acc;
                settleCnt    <= SETTLE_LOAD;
            end
            if (state == DRIVE && !capture) settleCnt <= settleCnt - 1'b1;
            if (capture) begin
                rsp_data  <= alu_out;
                rsp_op    <= alu_op;
                rsp_valid <= 1'b1;
                if (wrAccLatched) acc <= alu_out;
            end
            if (rspDone) rsp_valid <= 1'b0;
        end
    end

`ifdef ALU_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       rsp_flags <= '0;
        else if (capture) rsp_flags <= {alu_out[WIDTH-1], (alu_out == '0)};
    end
`endif

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer: two instances (SETTLE_CYCLES=1 and 3) each driving a behavioural ALU.
module tb_alu_op_issuer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] aluModel(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        logic [15:0] t;
        t = {a, a} << b[2:0];
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return t[15:8];
            3'd3:    return a ^ b;
            3'd4:    return a | b;
            3'd5:    return a & b;
            3'd6:    return b;
            default: return a;
        endcase
    endfunction

    // Instance 1: SETTLE_CYCLES=1, ACC_RESET=0
    logic       rst1_n, reqValid1, reqReady1, useAcc1, wrAcc1, rspValid1, rspReady1, busy1;
    logic [2:0] reqOp1, aluOp1, rspOp1;
    logic [7:0] reqA1, reqB1, aluA1, aluB1, aluOut1, rspData1, acc1;
`ifdef ALU_FLAGS_EN
    logic [1:0] rspFlags1;
`endif
    assign aluOut1 = aluModel(aluA1, aluB1, aluOp1);

    alu_op_issuer #(.WIDTH(8), .SETTLE_CYCLES(1), .ACC_RESET(8'h00)) dut1 (
        .clk(clk), .rst_n(rst1_n), .req_valid(reqValid1), .req_ready(reqReady1),
        .req_op(reqOp1), .req_a(reqA1), .req_b(reqB1), .req_use_acc(useAcc1), .req_wr_acc(wrAcc1),
        .alu_a(aluA1), .alu_b(aluB1), .alu_op(aluOp1), .alu_out(aluOut1),
        .rsp_valid(rspValid1), .rsp_ready(rspReady1), .rsp_data(rspData1), .rsp_op(rspOp1),
        .acc(acc1), .busy(busy1)
`ifdef ALU_FLAGS_EN
        , .rsp_flags(rspFlags1)
`endif
    );

    // Instance 2: SETTLE_CYCLES=3, ACC_RESET=0x5A
    logic       rst2_n, reqValid2, reqReady2, useAcc2, wrAcc2, rspValid2, rspReady2, busy2;
    logic [2:0] reqOp2, aluOp2, rspOp2;
    logic [7:0] reqA2, reqB2, aluA2, aluB2, aluOut2, rspData2, acc2;
`ifdef ALU_FLAGS_EN
    logic [1:0] rspFlags2;
`endif
    assign aluOut2 = aluModel(aluA2, aluB2, aluOp2);

    alu_op_issuer #(.WIDTH(8), .SETTLE_CYCLES(3), .ACC_RESET(8'h5A)) dut2 (
        .clk(clk), .rst_n(rst2_n), .req_valid(reqValid2), .req_ready(reqReady2),
        .req_op(reqOp2), .req_a(reqA2), .req_b(reqB2), .req_use_acc(useAcc2), .req_wr_acc(wrAcc2),
        .alu_a(aluA2), .alu_b(aluB2), .alu_op(aluOp2), .alu_out(aluOut2),
        .rsp_valid(rspValid2), .rsp_ready(rspReady2), .rsp_data(rspData2), .rsp_op(rspOp2),
        .acc(acc2), .busy(busy2)
`ifdef ALU_FLAGS_EN
        , .rsp_flags(rspFlags2)
`endif
    );

    int nCmp = 0;
    int nBad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCmp++;
        if (act !== exp) begin
            nBad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       useAcc;
        logic       wrAcc;
        logic [7:0] expAluA;
        logic [7:0] expData;
        logic [7:0] expAcc;
        logic [1:0] expFlags;
    } vecT;

    vecT vecs[9];

    // Issue one op on dut1 from a posedge+1 time point; leaves the time at posedge+1.
    task automatic issue1(input vecT v, input bit doHandshake);
        int lat;
        chk("req_ready_before_issue", 32'(reqReady1), 32'd1);
        reqOp1 = v.op; reqA1 = v.a; reqB1 = v.b; useAcc1 = v.useAcc; wrAcc1 = v.wrAcc;
        reqValid1 = 1'b1;
        @(posedge clk); #1;
        reqValid1 = 1'b0;
        chk("alu_a", 32'(aluA1), 32'(v.expAluA));
        chk("alu_b", 32'(aluB1), 32'(v.b));
        chk("alu_op", 32'(aluOp1), 32'(v.op));
        chk("busy_drive", 32'(busy1), 32'd1);
        chk("req_ready_drive", 32'(reqReady1), 32'd0);
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (rspValid1) break;
        end
        chk("latency", 32'(lat), 32'd1);
        chk("rsp_data", 32'(rspData1), 32'(v.expData));
        chk("rsp_op", 32'(rspOp1), 32'(v.op));
        chk("acc", 32'(acc1), 32'(v.expAcc));
`ifdef ALU_FLAGS_EN
        chk("rsp_flags", 32'(rspFlags1), 32'(v.expFlags));
`endif
        if (doHandshake) begin
            rspReady1 = 1'b1;
            @(posedge clk); #1;
            rspReady1 = 1'b0;
            chk("rsp_valid_after_hs", 32'(rspValid1), 32'd0);
            chk("req_ready_after_hs", 32'(reqReady1), 32'd1);
        end
    endtask

    initial begin
        vecT v;
        //           op    a      b      ua    wa    aluA   data   acc    flags
        vecs[0] = '{3'd0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h7F, 8'h80, 8'h00, 2'b10};
        vecs[1] = '{3'd1, 8'h05, 8'h07, 1'b0, 1'b1, 8'h05, 8'hFE, 8'hFE, 2'b10};
        vecs[2] = '{3'd3, 8'h00, 8'hFF, 1'b1, 1'b0, 8'hFE, 8'h01, 8'hFE, 2'b00};
        vecs[3] = '{3'd2, 8'h81, 8'hF9, 1'b0, 1'b0, 8'h81, 8'h03, 8'hFE, 2'b00};
        vecs[4] = '{3'd6, 8'h00, 8'h3C, 1'b0, 1'b1, 8'h00, 8'h3C, 8'h3C, 2'b00};
        vecs[5] = '{3'd0, 8'h99, 8'h04, 1'b1, 1'b1, 8'h3C, 8'h40, 8'h40, 2'b00};
        vecs[6] = '{3'd1, 8'h00, 8'h01, 1'b0, 1'b0, 8'h00, 8'hFF, 8'h40, 2'b10};
        vecs[7] = '{3'd5, 8'hAA, 8'h55, 1'b0, 1'b0, 8'hAA, 8'h00, 8'h40, 2'b01};
        vecs[8] = '{3'd0, 8'h80, 8'h00, 1'b0, 1'b0, 8'h80, 8'h80, 8'h40, 2'b10};

        reqValid1 = 0; reqOp1 = 0; reqA1 = 0; reqB1 = 0; useAcc1 = 0; wrAcc1 = 0; rspReady1 = 0;
        reqValid2 = 0; reqOp2 = 0; reqA2 = 0; reqB2 = 0; useAcc2 = 0; wrAcc2 = 0; rspReady2 = 0;
        rst1_n = 1'b1; rst2_n = 1'b1;
        #2;
        rst1_n = 1'b0; rst2_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(reqReady1), 32'd0);
        chk("rst_rsp_valid", 32'(rspValid1), 32'd0);
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_alu_a", 32'(aluA1), 32'd0);
        chk("rst_alu_op", 32'(aluOp1), 32'd0);
        chk("rst_rsp_data", 32'(rspData1), 32'd0);
        chk("rst_acc1", 32'(acc1), 32'h00);
        chk("rst_acc2", 32'(acc2), 32'h5A);
        rst1_n = 1'b1; rst2_n = 1'b1;
        #1;
        chk("req_ready_at_release", 32'(reqReady1), 32'd0);
        @(posedge clk); #1;
        chk("req_ready_first_edge", 32'(reqReady1), 32'd1);
        chk("req_ready2_first_edge", 32'(reqReady2), 32'd1);

        for (int i = 0; i < 9; i++) issue1(vecs[i], 1'b1);

        // Backpressure: response held, extra request ignored, then re-presented and accepted.
        v = '{3'd0, 8'h10, 8'h20, 1'b0, 1'b0, 8'h10, 8'h30, 8'h40, 2'b00};
        issue1(v, 1'b0);
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                reqOp1 = 3'd7; reqA1 = 8'h55; reqB1 = 8'h00; useAcc1 = 0; wrAcc1 = 0;
                reqValid1 = 1'b1;
            end
            if (k == 2) reqValid1 = 1'b0;
            @(posedge clk); #1;
            chk("bp_rsp_valid", 32'(rspValid1), 32'd1);
            chk("bp_rsp_data", 32'(rspData1), 32'h30);
            chk("bp_req_ready", 32'(reqReady1), 32'd0);
            chk("bp_alu_op", 32'(aluOp1), 32'd0);
        end
        rspReady1 = 1'b1;
        @(posedge clk); #1;
        rspReady1 = 1'b0;
        chk("bp_rsp_valid_cleared", 32'(rspValid1), 32'd0);
        v = '{3'd7, 8'h55, 8'h00, 1'b0, 1'b0, 8'h55, 8'h55, 8'h40, 2'b00};
        issue1(v, 1'b1);

        // Settle window of 3 on dut2.
        reqOp2 = 3'd4; reqA2 = 8'hF0; reqB2 = 8'h0F; useAcc2 = 0; wrAcc2 = 0;
        reqValid2 = 1'b1;
        @(posedge clk); #1;
        reqValid2 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("s3_alu_a", 32'(aluA2), 32'hF0);
            chk("s3_alu_b", 32'(aluB2), 32'h0F);
            chk("s3_alu_op", 32'(aluOp2), 32'd4);
            chk("s3_busy", 32'(busy2), 32'd1);
            chk("s3_rsp_valid_early", 32'(rspValid2), 32'd0);
            @(posedge clk); #1;
        end
        chk("s3_rsp_valid", 32'(rspValid2), 32'd1);
        chk("s3_rsp_data", 32'(rspData2), 32'hFF);
        chk("s3_busy_resp", 32'(busy2), 32'd1);
        chk("s3_acc", 32'(acc2), 32'h5A);
        rspReady2 = 1'b1;
        @(posedge clk); #1;
        rspReady2 = 1'b0;
        chk("s3_req_ready_after_hs", 32'(reqReady2), 32'd1);

        // Reset in the second DRIVE cycle drops the op and its acc write.
        reqOp2 = 3'd6; reqA2 = 8'h00; reqB2 = 8'h77; wrAcc2 = 1'b1;
        reqValid2 = 1'b1;
        @(posedge clk); #1;
        reqValid2 = 1'b0;
        @(posedge clk); #2;
        rst2_n = 1'b0;
        #1;
        chk("mr_busy", 32'(busy2), 32'd0);
        chk("mr_acc", 32'(acc2), 32'h5A);
        chk("mr_req_ready", 32'(reqReady2), 32'd0);
        @(posedge clk); #1;
        rst2_n = 1'b1;
        #1;
        chk("mr_req_ready_release", 32'(reqReady2), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (k == 0) chk("mr_req_ready_first_edge", 32'(reqReady2), 32'd1);
            chk("mr_rsp_valid", 32'(rspValid2), 32'd0);
            chk("mr_acc_hold", 32'(acc2), 32'h5A);
            chk("mr_busy_idle", 32'(busy2), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
